fx2_slave_fifo_responder: RTL and testbench

//   Synthesizable responder for the CY68013 (FX2) slave-FIFO bus: the device-side end of the

---
 rtl/fx2_slave_fifo_if.sv | 41 ++++
 rtl/fx2_slave_fifo_responder.sv | 94 +++++++++
 tb/tb_fx2_slave_fifo_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fx2_slave_fifo_if.sv
// Slave-FIFO bus between the FPGA-side USB master and the FX2 responder model,
// plus the host-side valid/ready ports of the two endpoint FIFOs.
interface fx2_slave_fifo_if #(
    parameter int DATA_W = 16
);
    logic [1:0]        usb_fifoaddr;
    logic              usb_slcs;
    logic              usb_sloe;
    logic              usb_slrd;
    logic              usb_slwr;
    logic [DATA_W-1:0] usb_fd_in;
    logic [DATA_W-1:0] usb_fd_out;
    logic              usb_fd_oe;
    logic              usb_flaga;
    logic              usb_flagb;
    logic              usb_flagc;
    logic              host_wr_valid;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_wr_ready;
    logic              host_rd_valid;
    logic [DATA_W-1:0] host_rd_data;
    logic              host_rd_ready;
    logic              ep2_underflow;
    logic              ep6_overflow;

    modport slave (
        input  usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_in,
        input  host_wr_valid, host_wr_data, host_rd_ready,
        output usb_fd_out, usb_fd_oe, usb_flaga, usb_flagb, usb_flagc,
        output host_wr_ready, host_rd_valid, host_rd_data,
        output ep2_underflow, ep6_overflow
    );

    modport master (
        output usb_fifoaddr, usb_slcs, usb_sloe, usb_slrd, usb_slwr, usb_fd_in,
        output host_wr_valid, host_wr_data, host_rd_ready,
        input  usb_fd_out, usb_fd_oe, usb_flaga, usb_flagb, usb_flagc,
        input  host_wr_ready, host_rd_valid, host_rd_data,
        input  ep2_underflow, ep6_overflow
    );
endinterface

// File: rtl/fx2_slave_fifo_responder.sv
// FX2 slave-FIFO responder: EP2 OUT FIFO (host -> master reads) and EP6 IN FIFO
// (master writes -> host), both first-word fall-through, with registered flags.
module fx2_slave_fifo_responder #(
    parameter int DATA_W = 16,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    fx2_slave_fifo_if.slave   bus
);
    localparam int         DEPTH = 2**AW;
    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

    logic [DATA_W-1:0] ep2_mem [DEPTH];
    logic [DATA_W-1:0] ep6_mem [DEPTH];

    logic [AW-1:0] ep2_wptr, ep2_rptr, ep6_wptr, ep6_rptr;
    logic [AW:0]   ep2_cnt, ep2_cnt_nxt, ep6_cnt, ep6_cnt_nxt;

    logic flaga_q, flagc_q, wr_ready_q, rd_valid_q, underflow_q, overflow_q;
    logic sel, rd_ev, wr_ev;
    logic ep2_push, ep2_pop, ep6_push, ep6_pop;

    assign sel   = ~bus.usb_slcs;
    assign rd_ev = sel & ~bus.usb_slrd & (bus.usb_fifoaddr == 2'b00);
    assign wr_ev = sel & ~bus.usb_slwr & (bus.usb_fifoaddr == 2'b10);

    // Handshakes use the pre-edge counts, so a slot freed by a pop is only usable next cycle.
    assign ep2_push = bus.host_wr_valid & wr_ready_q;
    assign ep2_pop  = rd_ev & (ep2_cnt != '0);
    assign ep6_push = wr_ev & (ep6_cnt != FULL);
    assign ep6_pop  = bus.host_rd_ready & rd_valid_q;

    always_comb begin
        ep2_cnt_nxt = ep2_cnt;
        if (ep2_push && !ep2_pop)
            ep2_cnt_nxt = ep2_cnt + 1'b1;
        else if (!ep2_push && ep2_pop)
            ep2_cnt_nxt = ep2_cnt - 1'b1;

        ep6_cnt_nxt = ep6_cnt;
        if (ep6_push && !ep6_pop)
            ep6_cnt_nxt = ep6_cnt + 1'b1;
        else if (!ep6_push && ep6_pop)
            ep6_cnt_nxt = ep6_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ep2_wptr    <= '0;
            ep2_rptr    <= '0;
            ep6_wptr    <= '0;
            ep6_rptr    <= '0;
            ep2_cnt     <= '0;
            ep6_cnt     <= '0;
            flaga_q     <= 1'b0;
            flagc_q     <= 1'b1;
            wr_ready_q  <= 1'b1;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (ep2_push) ep2_wptr <= ep2_wptr + 1'b1;
            if (ep2_pop)  ep2_rptr <= ep2_rptr + 1'b1;
            if (ep6_push) ep6_wptr <= ep6_wptr + 1'b1;
            if (ep6_pop)  ep6_rptr <= ep6_rptr + 1'b1;
            ep2_cnt    <= ep2_cnt_nxt;
            ep6_cnt    <= ep6_cnt_nxt;
            flaga_q    <= (ep2_cnt_nxt != '0);
            wr_ready_q <= (ep2_cnt_nxt != FULL);
            rd_valid_q <= (ep6_cnt_nxt != '0);
            flagc_q    <= (ep6_cnt_nxt != FULL);
            if (rd_ev && (ep2_cnt == '0))  underflow_q <= 1'b1;
            if (wr_ev && (ep6_cnt == FULL)) overflow_q <= 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && ep2_push) ep2_mem[ep2_wptr] <= bus.host_wr_data;
        if (reset_n && ep6_push) ep6_mem[ep6_wptr] <= bus.usb_fd_in;
    end

    assign bus.usb_fd_oe     = sel & ~bus.usb_sloe & (bus.usb_fifoaddr == 2'b00);
    assign bus.usb_fd_out    = bus.usb_fd_oe ? ep2_mem[ep2_rptr] : '0;
    assign bus.usb_flaga     = flaga_q;
    assign bus.usb_flagb     = 1'b0;
    assign bus.usb_flagc     = flagc_q;
    assign bus.host_wr_ready = wr_ready_q;
    assign bus.host_rd_valid = rd_valid_q;
    assign bus.host_rd_data  = ep6_mem[ep6_rptr];
    assign bus.ep2_underflow = underflow_q;
    assign bus.ep6_overflow  = overflow_q;
endmodule

// File: tb/tb_fx2_slave_fifo_responder.sv
// Bench for the FX2 slave-FIFO responder: directed scenarios plus a randomized run,
// all checked against queue-based endpoint models.
module tb_fx2_slave_fifo_responder;
    localparam int DATA_W = 16;
    localparam int AW     = 9;
    localparam int DEPTH  = 512;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fx2_slave_fifo_if #(.DATA_W(DATA_W)) bus ();

    fx2_slave_fifo_responder #(.DATA_W(DATA_W), .AW(AW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] q2[$];
    logic [15:0] q6[$];
    bit m_unf, m_ovf;

    task automatic idle();
        bus.usb_fifoaddr  = 2'd0;
        bus.usb_slcs      = 1'b1;
        bus.usb_sloe      = 1'b1;
        bus.usb_slrd      = 1'b1;
        bus.usb_slwr      = 1'b1;
        bus.usb_fd_in     = '0;
        bus.host_wr_valid = 1'b0;
        bus.host_wr_data  = '0;
        bus.host_rd_ready = 1'b0;
    endtask

    // One clock: the model decides from pre-edge occupancy, then the edge happens.
    task automatic step();
        bit sel, rd, wr, push2, pop2, push6, pop6;
        logic [15:0] d2, d6;
        sel   = !bus.usb_slcs;
        rd    = sel && !bus.usb_slrd && (bus.usb_fifoaddr == 2'd0);
        wr    = sel && !bus.usb_slwr && (bus.usb_fifoaddr == 2'd2);
        push2 = bus.host_wr_valid && (q2.size() < DEPTH);
        pop2  = rd && (q2.size() != 0);
        push6 = wr && (q6.size() < DEPTH);
        pop6  = bus.host_rd_ready && (q6.size() != 0);
        d2    = bus.host_wr_data;
        d6    = bus.usb_fd_in;
        @(posedge clk);
        if (!reset_n) begin
            q2.delete();
            q6.delete();
            m_unf = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (rd && !pop2) m_unf = 1'b1;
            if (wr && !push6) m_ovf = 1'b1;
            if (pop2) void'(q2.pop_front());
            if (push2) q2.push_back(d2);
            if (pop6) void'(q6.pop_front());
            if (push6) q6.push_back(d6);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        idle();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        #1;
        checks++; if (bus.usb_flaga !== 1'b0) begin errors++; $display("FAIL reset_flaga got %b exp 0", bus.usb_flaga); end
        checks++; if (bus.usb_flagb !== 1'b0) begin errors++; $display("FAIL reset_flagb got %b exp 0", bus.usb_flagb); end
        checks++; if (bus.usb_flagc !== 1'b1) begin errors++; $display("FAIL reset_flagc got %b exp 1", bus.usb_flagc); end
        checks++; if (bus.usb_fd_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", bus.usb_fd_oe); end
        checks++; if (bus.host_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", bus.host_rd_valid); end
        checks++; if (bus.host_wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", bus.host_wr_ready); end
        checks++; if ({bus.ep2_underflow, bus.ep6_overflow} !== 2'b00) begin errors++; $display("FAIL reset_sticky got %b exp 00", {bus.ep2_underflow, bus.ep6_overflow}); end
    endtask

    task automatic test_ep2_read();
        bus.host_wr_valid = 1'b1;
        bus.host_wr_data  = 16'h1234;
        step();
        bus.host_wr_data  = 16'hABCD;
        step();
        bus.host_wr_valid = 1'b0;
        bus.usb_slcs = 1'b0;
        bus.usb_sloe = 1'b0;
        bus.usb_fifoaddr = 2'd0;
        #1;
        checks++; if (bus.usb_fd_oe !== 1'b1) begin errors++; $display("FAIL ep2_oe got %b exp 1", bus.usb_fd_oe); end
        checks++; if (bus.usb_fd_out !== 16'h1234) begin errors++; $display("FAIL ep2_head0 got %h exp 1234", bus.usb_fd_out); end
        checks++; if (bus.usb_flaga !== 1'b1) begin errors++; $display("FAIL ep2_flaga_full got %b exp 1", bus.usb_flaga); end
        bus.usb_slrd = 1'b0;
        step();
        bus.usb_slrd = 1'b1;
        #1;
        checks++; if (bus.usb_fd_out !== 16'hABCD) begin errors++; $display("FAIL ep2_head1 got %h exp abcd", bus.usb_fd_out); end
        bus.usb_slrd = 1'b0;
        step();
        bus.usb_slrd = 1'b1;
        #1;
        checks++; if (bus.usb_flaga !== 1'b0) begin errors++; $display("FAIL ep2_flaga_empty got %b exp 0", bus.usb_flaga); end
        checks++; if (bus.ep2_underflow !== 1'b0) begin errors++; $display("FAIL ep2_no_underflow got %b exp 0", bus.ep2_underflow); end
        idle();
    endtask

    task automatic test_ep6_fill();
        int bad;
        bus.usb_slcs = 1'b0;
        bus.usb_fifoaddr = 2'd2;
        bus.usb_slwr = 1'b0;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.usb_fd_in = 16'(i);
            step();
            if (bus.usb_flagc !== (i < DEPTH - 1)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL ep6_flagc_fill got %0d wrong cycles exp 0", bad); end
        checks++; if (bus.usb_flagc !== 1'b0) begin errors++; $display("FAIL ep6_full got %b exp 0", bus.usb_flagc); end
        bus.usb_fd_in = 16'hDEAD;
        step();
        idle();
        #1;
        checks++; if (bus.ep6_overflow !== 1'b1) begin errors++; $display("FAIL ep6_overflow got %b exp 1", bus.ep6_overflow); end
        bus.host_rd_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.host_rd_valid !== 1'b1 || bus.host_rd_data !== 16'(i)) bad++;
            step();
            if (i == 0) begin
                checks++; if (bus.usb_flagc !== 1'b1) begin errors++; $display("FAIL ep6_flagc_after_pop got %b exp 1", bus.usb_flagc); end
            end
        end
        bus.host_rd_ready = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL ep6_drain_order got %0d wrong words exp 0", bad); end
        checks++; if (bus.host_rd_valid !== 1'b0) begin errors++; $display("FAIL ep6_drained got %b exp 0", bus.host_rd_valid); end
    endtask

    task automatic test_underflow();
        pulse_reset();
        bus.usb_slcs = 1'b0;
        bus.usb_sloe = 1'b0;
        bus.usb_fifoaddr = 2'd0;
        bus.usb_slrd = 1'b0;
        step();
        bus.usb_slrd = 1'b1;
        #1;
        checks++; if (bus.ep2_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %b exp 1", bus.ep2_underflow); end
        checks++; if (bus.usb_flaga !== 1'b0) begin errors++; $display("FAIL underflow_flaga got %b exp 0", bus.usb_flaga); end
        bus.host_wr_valid = 1'b1;
        bus.host_wr_data  = 16'h7777;
        step();
        bus.host_wr_valid = 1'b0;
        #1;
        checks++; if (bus.usb_fd_out !== 16'h7777) begin errors++; $display("FAIL underflow_ptr_head got %h exp 7777", bus.usb_fd_out); end
    endtask

    task automatic test_simultaneous();
        bus.host_wr_valid = 1'b1;
        bus.host_wr_data  = 16'h5555;
        bus.usb_slrd = 1'b0;
        step();
        bus.host_wr_valid = 1'b0;
        bus.usb_slrd = 1'b1;
        #1;
        checks++; if (bus.usb_flaga !== 1'b1) begin errors++; $display("FAIL simul_flaga got %b exp 1", bus.usb_flaga); end
        checks++; if (bus.usb_fd_out !== 16'h5555) begin errors++; $display("FAIL simul_head got %h exp 5555", bus.usb_fd_out); end
        checks++; if (bus.ep2_underflow !== 1'b1) begin errors++; $display("FAIL simul_sticky got %b exp 1", bus.ep2_underflow); end
    endtask

    task automatic test_ignored();
        logic [1:0] addrs [4];
        addrs[0] = 2'd1; addrs[1] = 2'd3; addrs[2] = 2'd0; addrs[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            bus.usb_fifoaddr = addrs[k];
            bus.usb_fd_in = 16'($urandom);
            bus.usb_slcs = (k >= 2) ? 1'b1 : 1'b0;
            bus.usb_slrd = 1'b0;
            bus.usb_slwr = 1'b0;
            step();
        end
        bus.usb_slcs = 1'b0;
        bus.usb_fifoaddr = 2'd0;
        bus.usb_slrd = 1'b1;
        bus.usb_slwr = 1'b0;
        step();
        bus.usb_slwr = 1'b1;
        #1;
        checks++; if (bus.usb_fd_out !== 16'h5555) begin errors++; $display("FAIL ignored_head got %h exp 5555", bus.usb_fd_out); end
        checks++; if ({bus.usb_flaga, bus.usb_flagc, bus.host_rd_valid, bus.ep6_overflow} !== 4'b1100) begin errors++; $display("FAIL ignored_flags got %b exp 1100", {bus.usb_flaga, bus.usb_flagc, bus.host_rd_valid, bus.ep6_overflow}); end
        bus.usb_slrd = 1'b0;
        bus.usb_slwr = 1'b0;
        step();
        idle();
        #1;
        checks++; if ({bus.usb_flaga, bus.host_rd_valid} !== 2'b00) begin errors++; $display("FAIL both_strobes got %b exp 00", {bus.usb_flaga, bus.host_rd_valid}); end
    endtask

    task automatic test_reset_mid();
        bus.usb_slcs = 1'b0;
        bus.usb_fifoaddr = 2'd2;
        bus.usb_slwr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.usb_fd_in = 16'(100 + i);
            step();
        end
        checks++; if (bus.host_rd_valid !== 1'b1) begin errors++; $display("FAIL mid_loaded got %b exp 1", bus.host_rd_valid); end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        idle();
        #1;
        checks++; if ({bus.host_rd_valid, bus.usb_flagc, bus.ep6_overflow, bus.ep2_underflow} !== 4'b0100) begin errors++; $display("FAIL mid_reset got %b exp 0100", {bus.host_rd_valid, bus.usb_flagc, bus.ep6_overflow, bus.ep2_underflow}); end
    endtask

    task automatic test_random();
        bit oe_exp;
        pulse_reset();
        for (int n = 0; n < 1500; n++) begin
            bus.usb_slcs      = ($urandom_range(0, 3) == 0);
            bus.usb_sloe      = 1'($urandom);
            bus.usb_slrd      = ($urandom_range(0, 2) != 0);
            bus.usb_slwr      = ($urandom_range(0, 2) == 0);
            bus.usb_fifoaddr  = 2'($urandom);
            bus.usb_fd_in     = 16'($urandom);
            bus.host_wr_valid = 1'($urandom);
            bus.host_wr_data  = 16'($urandom);
            bus.host_rd_ready = (n < 750) ? ($urandom_range(0, 5) == 0) : 1'($urandom);
            step();
            #1;
            oe_exp = !bus.usb_slcs && !bus.usb_sloe && (bus.usb_fifoaddr == 2'd0);
            checks++; if (bus.usb_flaga !== (q2.size() != 0)) begin errors++; $display("FAIL rnd_flaga cyc %0d got %b exp %b", n, bus.usb_flaga, q2.size() != 0); end
            checks++; if (bus.host_wr_ready !== (q2.size() != DEPTH)) begin errors++; $display("FAIL rnd_wr_ready cyc %0d got %b", n, bus.host_wr_ready); end
            checks++; if (bus.usb_flagc !== (q6.size() != DEPTH)) begin errors++; $display("FAIL rnd_flagc cyc %0d got %b", n, bus.usb_flagc); end
            checks++; if (bus.host_rd_valid !== (q6.size() != 0)) begin errors++; $display("FAIL rnd_rd_valid cyc %0d got %b exp %b", n, bus.host_rd_valid, q6.size() != 0); end
            checks++; if (bus.usb_flagb !== 1'b0) begin errors++; $display("FAIL rnd_flagb cyc %0d got %b exp 0", n, bus.usb_flagb); end
            checks++; if ({bus.ep2_underflow, bus.ep6_overflow} !== {m_unf, m_ovf}) begin errors++; $display("FAIL rnd_sticky cyc %0d got %b exp %b", n, {bus.ep2_underflow, bus.ep6_overflow}, {m_unf, m_ovf}); end
            checks++; if (bus.usb_fd_oe !== oe_exp) begin errors++; $display("FAIL rnd_oe cyc %0d got %b exp %b", n, bus.usb_fd_oe, oe_exp); end
            if (!oe_exp) begin
                checks++; if (bus.usb_fd_out !== 16'h0) begin errors++; $display("FAIL rnd_fd_idle cyc %0d got %h exp 0", n, bus.usb_fd_out); end
            end else if (q2.size() != 0) begin
                checks++; if (bus.usb_fd_out !== q2[0]) begin errors++; $display("FAIL rnd_fd_out cyc %0d got %h exp %h", n, bus.usb_fd_out, q2[0]); end
            end
            if (q6.size() != 0) begin
                checks++; if (bus.host_rd_data !== q6[0]) begin errors++; $display("FAIL rnd_rd_data cyc %0d got %h exp %h", n, bus.host_rd_data, q6[0]); end
            end
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_ep2_read();
        test_ep6_fill();
        test_underflow();
        test_simultaneous();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
